// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, FSM state encoding and the saturating narrow
// helper for the fully-connected layer sequencer.
package fc_pkg;

    localparam int NUM_INPUTS  = 225;
    localparam int NUM_OUTPUTS = 10;
    localparam int DATA_W      = 22;
    localparam int WEIGHT_W    = 16;
    localparam int BIAS_W      = 32;
    localparam int ACC_W       = 48;
    localparam int RES_W       = 32;

    localparam int PROD_W   = DATA_W + WEIGHT_W;
    localparam int RD_IDX_W = 8;
    localparam int W_ADDR_W = $clog2(NUM_INPUTS * NUM_OUTPUTS);
    localparam int NEURON_W = $clog2(NUM_OUTPUTS);

    // Signed RES_W limits expressed at accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] RES_MAX_EXT =
        {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN_EXT =
        {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MAC    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_DONE   = 3'd5
    } fc_state_e;

    // Clamp a signed accumulator value into the signed RES_W range.
    function automatic logic [RES_W-1:0] sat_narrow(input logic [ACC_W-1:0] val);
        logic signed [ACC_W-1:0] sval;
        logic [RES_W-1:0]        res;
        sval = $signed(val);
        if (sval > RES_MAX_EXT) begin
            res = {1'b0, {(RES_W-1){1'b1}}};
        end else if (sval < RES_MIN_EXT) begin
            res = {1'b1, {(RES_W-1){1'b0}}};
        end else begin
            res = val[RES_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_mac.sv
// fc_mac: signed multiply-accumulate datapath. The accumulator can be
// cleared, loaded with a bias, or advanced by one full-precision product.
// acc_next exposes the value the register takes on the coming edge so the
// caller can capture a result in the same cycle as the final accumulate.
module fc_mac
    import fc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              acc_en,
    input  logic [ACC_W-1:0]  load_val,
    input  logic [DATA_W-1:0] a,
    input  logic [WEIGHT_W-1:0] b,
    output logic [ACC_W-1:0]  acc_next
);

    logic [PROD_W-1:0] a_ext_s;
    logic [PROD_W-1:0] b_ext_s;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  prod_ext_s;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_nxt_s;

    // Sign-extend operands to product width; the low PROD_W bits of the
    // unsigned product equal the exact signed product.
    assign a_ext_s    = {{WEIGHT_W{a[DATA_W-1]}}, a};
    assign b_ext_s    = {{DATA_W{b[WEIGHT_W-1]}}, b};
    assign prod_s     = a_ext_s * b_ext_s;
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};

    // Select the accumulator update: clear wins over load, load over accumulate.
    always_comb begin
        acc_nxt_s = acc_r;
        if (clr) begin
            acc_nxt_s = {ACC_W{1'b0}};
        end else if (load) begin
            acc_nxt_s = load_val;
        end else if (acc_en) begin
            acc_nxt_s = acc_r + prod_ext_s;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

    assign acc_next = acc_nxt_s;

endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: walks every (neuron, input) pair of a fully-connected
// layer over the flatten buffer, accumulates bias + sum(data*weight),
// saturates and hands each neuron result downstream on valid/ready.
// Build option: define FC_RELU_EN to clamp negative results to zero.
module fc_layer_sequencer
    import fc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_buffer_full,
    output logic [RD_IDX_W-1:0] o_rd_idx,
    input  logic [DATA_W-1:0]   i_rd_data,
    output logic [W_ADDR_W-1:0] o_w_addr,
    input  logic [WEIGHT_W-1:0] i_weight,
    output logic [NEURON_W-1:0] o_neuron_idx,
    input  logic [BIAS_W-1:0]   i_bias,
    output logic [RES_W-1:0]    o_result,
    output logic                o_result_valid,
    input  logic                i_result_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [RD_IDX_W-1:0] LAST_IDX    = RD_IDX_W'(NUM_INPUTS - 1);
    localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(NUM_OUTPUTS - 1);
    localparam logic [W_ADDR_W-1:0] ROW_STRIDE  = W_ADDR_W'(NUM_INPUTS);

    fc_state_e           state_r;
    logic [RD_IDX_W-1:0] rd_idx_r;
    logic [W_ADDR_W-1:0] w_addr_r;
    logic [NEURON_W-1:0] neuron_r;
    logic [RES_W-1:0]    result_r;
    logic                result_valid_r;
    logic                busy_r;
    logic                done_r;

    logic                mac_load_s;
    logic                mac_clr_s;
    logic                mac_en_s;
    logic [ACC_W-1:0]    bias_ext_s;
    logic [ACC_W-1:0]    acc_nxt_s;
    logic [RES_W-1:0]    sat_s;
    logic [RES_W-1:0]    res_s;
    logic [W_ADDR_W-1:0] row_base_s;

    assign bias_ext_s = {{(ACC_W-BIAS_W){i_bias[BIAS_W-1]}}, i_bias};
    assign row_base_s = W_ADDR_W'(neuron_r) * ROW_STRIDE;

    // Accumulator controls: the first MAC cycle has no operand pair yet,
    // and DRAIN folds in the product of the last address.
    always_comb begin
        mac_load_s = 1'b0;
        mac_clr_s  = 1'b0;
        mac_en_s   = 1'b0;
        case (state_r)
            ST_LOAD:  mac_load_s = 1'b1;
            ST_MAC:   mac_en_s   = (rd_idx_r != {RD_IDX_W{1'b0}});
            ST_DRAIN: mac_en_s   = 1'b1;
            ST_DONE:  mac_clr_s  = 1'b1;
            default:  mac_en_s   = 1'b0;
        endcase
    end

    fc_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr_s),
        .load     (mac_load_s),
        .acc_en   (mac_en_s),
        .load_val (bias_ext_s),
        .a        (i_rd_data),
        .b        (i_weight),
        .acc_next (acc_nxt_s)
    );

    // Saturate the final accumulator value and optionally rectify it.
    always_comb begin
        sat_s = sat_narrow(acc_nxt_s);
        res_s = sat_s;
`ifdef FC_RELU_EN
        if (sat_s[RES_W-1]) begin
            res_s = {RES_W{1'b0}};
        end else begin
            res_s = sat_s;
        end
`endif
    end

    // Sequencer FSM with registered addresses, handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            rd_idx_r       <= {RD_IDX_W{1'b0}};
            w_addr_r       <= {W_ADDR_W{1'b0}};
            neuron_r       <= {NEURON_W{1'b0}};
            result_r       <= {RES_W{1'b0}};
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start && i_buffer_full) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    rd_idx_r <= {RD_IDX_W{1'b0}};
                    w_addr_r <= row_base_s;
                    state_r  <= ST_MAC;
                end
                ST_MAC: begin
                    // Addresses stop at the last element; DRAIN consumes it.
                    if (rd_idx_r == LAST_IDX) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_idx_r <= rd_idx_r + 8'd1;
                        w_addr_r <= w_addr_r + 12'd1;
                    end
                end
                ST_DRAIN: begin
                    result_r       <= res_s;
                    result_valid_r <= 1'b1;
                    state_r        <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (i_result_ready) begin
                        result_valid_r <= 1'b0;
                        if (neuron_r == LAST_NEURON) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            neuron_r <= neuron_r + 4'd1;
                            state_r  <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_r   <= 1'b0;
                    neuron_r <= {NEURON_W{1'b0}};
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_idx       = rd_idx_r;
    assign o_w_addr       = w_addr_r;
    assign o_neuron_idx   = neuron_r;
    assign o_result       = result_r;
    assign o_result_valid = result_valid_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;

endmodule
